front_panel_ctrl: RTL

FRONT_PANEL_CTRL -- requirements
Module: front_panel_ctrl

---
 rtl/front_panel_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/front_panel_ctrl.sv
// front_panel_ctrl: synchronizes and debounces the operator front-panel
// switches, then turns momentary presses into single fixed-width command
// pulses (load / deposit / examine / continue) for the CPU.
// Build option FP_DEBOUNCE_EN: when defined, the full DB_CYCLES debounce
// window is used; when undefined (fast simulation) every debounce window
// collapses to one clock.
// H0 must match the halted major-state code used by state_machine.
module front_panel_ctrl #(
    parameter int          DB_CYCLES    = 16,
    parameter int          PULSE_CYCLES = 4,
    parameter logic [4:0]  H0           = 5'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] state,
    input  logic       sw_load,
    input  logic       sw_dep,
    input  logic       sw_exam,
    input  logic       sw_cont,
    input  logic       sw_halt,
    input  logic       sw_sstep,
    output logic       loadd,
    output logic       depd,
    output logic       examd,
    output logic       cont,
    output logic       halt,
    output logic       single_step,
    output logic       fp_busy
);

`ifdef FP_DEBOUNCE_EN
    localparam logic [7:0] DB_EFF = 8'(DB_CYCLES);
`else
    localparam logic [7:0] DB_EFF = 8'd1;
`endif
    localparam logic [3:0] PULSE_LIM = 4'(PULSE_CYCLES);

    // Bit order: 0 load, 1 dep, 2 exam, 3 cont, 4 halt, 5 single-step
    logic [5:0] sw_raw;
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    logic [3:0] mom;
    logic [1:0] tog_lvl;

    assign sw_raw = {sw_sstep, sw_halt, sw_cont, sw_exam, sw_dep, sw_load};
    assign mom    = sync2_q[3:0];

    // Two-flop synchronizer on every raw panel switch
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // One level debouncer per toggle switch (halt, single-step)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_toggle
            logic [7:0] cnt_q, cnt_d, cnt_inc;
            logic       lvl_q, lvl_d;

            assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

            // Count consecutive mismatches; any agreement restarts the count
            always_comb begin
                cnt_d = 8'd0;
                lvl_d = lvl_q;
                if (sync2_q[4+gi] != lvl_q) begin
                    if (cnt_inc >= DB_EFF) begin
                        lvl_d = sync2_q[4+gi];
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            // Debouncer state register
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= 8'd0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign tog_lvl[gi] = lvl_q;
        end
    endgenerate

    logic halt_q;
    logic sstep_q;

    // Registered copies of the debounced toggle levels drive the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q  <= 1'b0;
            sstep_q <= 1'b0;
        end else begin
            halt_q  <= tog_lvl[0];
            sstep_q <= tog_lvl[1];
        end
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_FIRE     = 2'd2,
        S_WAIT_REL = 2'd3
    } seq_state_t;

    seq_state_t seq_q, seq_d;
    logic [3:0] sel_q, sel_d;          // one-hot latched momentary switch
    logic [7:0] db_cnt_q, db_cnt_d, db_inc;
    logic [3:0] pulse_cnt_q, pulse_cnt_d, pulse_inc;
    logic [3:0] cmd_q, cmd_d;
    logic [3:0] pick;
    logic       halted;
    logic       allowed;

    assign db_inc    = (db_cnt_q == 8'hFF) ? db_cnt_q : db_cnt_q + 8'd1;
    assign pulse_inc = (pulse_cnt_q == 4'hF) ? pulse_cnt_q : pulse_cnt_q + 4'd1;
    assign halted    = (state == H0);

    // Fixed priority pick among momentary switches: load > dep > exam > cont
    always_comb begin
        pick = 4'b0000;
        if (mom[0])      pick = 4'b0001;
        else if (mom[1]) pick = 4'b0010;
        else if (mom[2]) pick = 4'b0100;
        else if (mom[3]) pick = 4'b1000;
    end

    // Every command needs the CPU halted; continue also needs halt off or single-step on
    always_comb begin
        allowed = halted;
        if (sel_q[3]) begin
            allowed = halted && (!halt_q || sstep_q);
        end
    end

    // Sequencer next-state and command pulse generation
    always_comb begin
        seq_d       = seq_q;
        sel_d       = sel_q;
        db_cnt_d    = db_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        cmd_d       = 4'b0000;
        case (seq_q)
            S_IDLE: begin
                db_cnt_d    = 8'd0;
                pulse_cnt_d = 4'd0;
                if (|mom) begin
                    sel_d = pick;
                    seq_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if ((mom & sel_q) == 4'b0000) begin
                    db_cnt_d = 8'd0;
                    seq_d    = S_IDLE;
                end else if (db_inc >= DB_EFF) begin
                    db_cnt_d = 8'd0;
                    if (allowed) begin
                        pulse_cnt_d = 4'd0;
                        cmd_d       = sel_q;
                        seq_d       = S_FIRE;
                    end else begin
                        seq_d = S_WAIT_REL;
                    end
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            S_FIRE: begin
                // Runs to completion regardless of switch or CPU state
                if (pulse_inc >= PULSE_LIM) begin
                    pulse_cnt_d = 4'd0;
                    seq_d       = S_WAIT_REL;
                end else begin
                    pulse_cnt_d = pulse_inc;
                    cmd_d       = sel_q;
                end
            end
            S_WAIT_REL: begin
                if (|mom) begin
                    db_cnt_d = 8'd0;
                end else if (db_inc >= DB_EFF) begin
                    db_cnt_d = 8'd0;
                    seq_d    = S_IDLE;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            default: begin
                seq_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset kills any pulse on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q       <= S_IDLE;
            sel_q       <= 4'b0000;
            db_cnt_q    <= 8'd0;
            pulse_cnt_q <= 4'd0;
            cmd_q       <= 4'b0000;
        end else begin
            seq_q       <= seq_d;
            sel_q       <= sel_d;
            db_cnt_q    <= db_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            cmd_q       <= cmd_d;
        end
    end

    assign loadd       = cmd_q[0];
    assign depd        = cmd_q[1];
    assign examd       = cmd_q[2];
    assign cont        = cmd_q[3];
    assign halt        = halt_q;
    assign single_step = sstep_q;
    assign fp_busy     = (seq_q != S_IDLE);

endmodule
